pwm_multichannel_gen: RTL and testbench

//  Parametrised N-channel PWM generator for the motor controller and LED indicators.

---
 rtl/pwm_pkg.sv | 43 ++++
 rtl/pwm_channel.sv | 91 +++++++++
 rtl/pwm_multichannel_gen.sv | 78 +++++++
 tb/tb_pwm_multichannel_gen.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multichannel PWM generator: duty decoding
// (magnitude/sign with saturation) and the per-period slew step.
package pwm_pkg;

    localparam int FN_W = 32;

    typedef struct packed {
        logic            sign;
        logic [FN_W-1:0] mag;
    } duty_t;

    // The most negative input has no positive twin, so it saturates one below.
    function automatic duty_t duty_decode(input logic [FN_W-1:0] raw,
                                          input int unsigned     in_w,
                                          input logic            signed_in);
        duty_t           d;
        logic [FN_W-1:0] mask;
        logic [FN_W-1:0] half;
        mask   = (FN_W'(1) << in_w) - FN_W'(1);
        half   = FN_W'(1) << (in_w - 1);
        d.sign = 1'b0;
        d.mag  = raw & mask;
        if (signed_in && raw[in_w-1]) begin
            d.sign = 1'b1;
            d.mag  = (~raw + FN_W'(1)) & mask;
            if (d.mag == half)
                d.mag = half - FN_W'(1);
        end
        return d;
    endfunction

    // Move cur toward tgt by at most step without overshooting; step 0 jumps.
    function automatic logic [FN_W-1:0] slew_toward(input logic [FN_W-1:0] cur,
                                                    input logic [FN_W-1:0] tgt,
                                                    input logic [FN_W-1:0] step);
        if (step == '0)
            return tgt;
        if (cur < tgt)
            return ((tgt - cur) > step) ? cur + step : tgt;
        return ((cur - tgt) > step) ? cur - step : tgt;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow duty register, boundary-applied slew/direction
// update and the registered counter compare.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int IN_W      = 10,
    parameter int CNT_W     = 16,
    parameter int OFFSET    = 250,
    parameter int DEADBAND  = 12,
    parameter int SIGNED_IN = 0,
    parameter int SLEW_STEP = 0
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             enable,
    input  logic             boundary,
    input  logic [CNT_W-1:0] cnt_nxt,
    input  logic [IN_W-1:0]  duty,
    input  logic             duty_valid,
    output logic             pwm_out,
    output logic             dir_out
);

    localparam int SUM_W = CNT_W + 1;
    localparam logic [IN_W-1:0]  DB  = IN_W'(DEADBAND);
    localparam logic [SUM_W-1:0] OFS = SUM_W'(OFFSET);

    logic [IN_W-1:0]  sh_mag;
    logic             sh_sign;
    logic [IN_W-1:0]  act;
    logic [IN_W-1:0]  act_nxt;
    logic             dir;
    logic             dir_nxt;
    logic [IN_W-1:0]  dec_mag;
    logic             dec_sign;
    logic [SUM_W-1:0] thr;
    logic             hit;
    duty_t            dec;

    always_comb begin
        dec      = duty_decode(FN_W'(duty), IN_W, SIGNED_IN != 0);
        dec_mag  = IN_W'(dec.mag);
        dec_sign = dec.sign;
    end

    // A reversal must bleed magnitude to zero before the direction may flip.
    always_comb begin
        act_nxt = act;
        dir_nxt = dir;
        if (boundary) begin
            if (SLEW_STEP == 0) begin
                act_nxt = sh_mag;
                dir_nxt = sh_sign;
            end else if (sh_sign != dir) begin
                act_nxt = IN_W'(slew_toward(FN_W'(act), '0, FN_W'(SLEW_STEP)));
                if (act_nxt == '0)
                    dir_nxt = sh_sign;
            end else begin
                act_nxt = IN_W'(slew_toward(FN_W'(act), FN_W'(sh_mag), FN_W'(SLEW_STEP)));
            end
        end
    end

    // Compare against the values the counter and magnitude take this edge so
    // the output lines up with period_start.
    always_comb begin
        thr = SUM_W'(act_nxt) + OFS;
        hit = (act_nxt > DB) && ({1'b0, cnt_nxt} < thr);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sh_mag  <= '0;
            sh_sign <= 1'b0;
            act     <= '0;
            dir     <= 1'b0;
            pwm_out <= 1'b0;
        end else begin
            if (duty_valid) begin
                sh_mag  <= dec_mag;
                sh_sign <= dec_sign;
            end
            act     <= act_nxt;
            dir     <= dir_nxt;
            pwm_out <= enable && hit;
        end
    end

    assign dir_out = dir;

endmodule

// File: rtl/pwm_multichannel_gen.sv
// N-channel PWM generator: shared prescaler and period counter, per-channel
// double-buffered duty applied only at period boundaries.
module pwm_multichannel_gen
    import pwm_pkg::*;
#(
    parameter int CHANNELS  = 2,
    parameter int IN_W      = 10,
    parameter int CNT_W     = 16,
    parameter int PRESCALE  = 128,
    parameter int PERIOD    = 530,
    parameter int OFFSET    = 250,
    parameter int DEADBAND  = 12,
    parameter int SIGNED_IN = 0,
    parameter int SLEW_STEP = 0
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [CHANNELS*IN_W-1:0] duty_in,
    input  logic [CHANNELS-1:0]      duty_valid,
    output logic [CHANNELS-1:0]      pwm_out,
    output logic [CHANNELS-1:0]      dir_out,
    output logic                     period_start
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PRE_W-1:0] pre;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             tick;
    logic             boundary;

    assign tick     = enable && (pre == PRE_W'(PRESCALE - 1));
    assign boundary = tick && (cnt == CNT_W'(PERIOD));

    always_comb begin
        cnt_nxt = cnt;
        if (!enable)
            cnt_nxt = '0;
        else if (tick)
            cnt_nxt = boundary ? '0 : cnt + CNT_W'(1);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pre          <= '0;
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            pre          <= (!enable || tick) ? '0 : pre + PRE_W'(1);
            cnt          <= cnt_nxt;
            period_start <= boundary;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel #(
            .IN_W      (IN_W),
            .CNT_W     (CNT_W),
            .OFFSET    (OFFSET),
            .DEADBAND  (DEADBAND),
            .SIGNED_IN (SIGNED_IN),
            .SLEW_STEP (SLEW_STEP)
        ) u_ch (
            .CLOCK_50   (CLOCK_50),
            .reset      (reset),
            .enable     (enable),
            .boundary   (boundary),
            .cnt_nxt    (cnt_nxt),
            .duty       (duty_in[i*IN_W +: IN_W]),
            .duty_valid (duty_valid[i]),
            .pwm_out    (pwm_out[i]),
            .dir_out    (dir_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_multichannel_gen.sv
// Bench for pwm_multichannel_gen: duty table, slew/boundary sequences and a
// randomized run checked every cycle against a behavioural model.
module tb_pwm_multichannel_gen;

    localparam int CH        = 2;
    localparam int IN_W      = 6;
    localparam int CNT_W     = 8;
    localparam int PRESCALE  = 2;
    localparam int PERIOD    = 19;
    localparam int OFFSET    = 2;
    localparam int DEADBAND  = 3;
    localparam int SIGNED_IN = 1;
    localparam int SLEW_STEP = 4;
    localparam int PCLK      = PRESCALE * (PERIOD + 1);

    logic                 CLOCK_50 = 1'b0;
    logic                 reset;
    logic                 enable;
    logic [CH*IN_W-1:0]   duty_in;
    logic [CH-1:0]        duty_valid;
    logic [CH-1:0]        pwm_out;
    logic [CH-1:0]        dir_out;
    logic                 period_start;

    pwm_multichannel_gen #(
        .CHANNELS(CH), .IN_W(IN_W), .CNT_W(CNT_W), .PRESCALE(PRESCALE),
        .PERIOD(PERIOD), .OFFSET(OFFSET), .DEADBAND(DEADBAND),
        .SIGNED_IN(SIGNED_IN), .SLEW_STEP(SLEW_STEP)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable), .duty_in(duty_in),
        .duty_valid(duty_valid), .pwm_out(pwm_out), .dir_out(dir_out),
        .period_start(period_start)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int duty_val[CH];
    int m_pre, m_cnt, m_ps;
    int m_sh[CH], m_act[CH], m_dir[CH], m_pwm[CH];
    int meas_hi[CH], meas_dir[CH];

    typedef struct {
        int duty;
        int exp_hi;
        int exp_dir;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic int ref_mag(input int v);
        int lim;
        lim = (1 << (IN_W - 1)) - 1;
        if (SIGNED_IN == 0) return v & ((1 << IN_W) - 1);
        if (v < 0) v = -v;
        return (v > lim) ? lim : v;
    endfunction

    function automatic int ref_sgn(input int v);
        return (SIGNED_IN != 0 && v < 0) ? 1 : 0;
    endfunction

    task automatic model_edge();
        bit tick, bnd;
        int tgt, sg;
        if (reset) begin
            m_pre = 0; m_cnt = 0; m_ps = 0;
            for (int c = 0; c < CH; c++) begin
                m_sh[c] = 0; m_act[c] = 0; m_dir[c] = 0; m_pwm[c] = 0;
            end
            return;
        end
        tick  = enable && (m_pre == PRESCALE - 1);
        bnd   = tick && (m_cnt == PERIOD);
        m_pre = (!enable || tick) ? 0 : m_pre + 1;
        m_cnt = !enable ? 0 : (tick ? (m_cnt + 1) % (PERIOD + 1) : m_cnt);
        for (int c = 0; c < CH; c++) begin
            if (bnd) begin
                tgt = ref_mag(m_sh[c]);
                sg  = ref_sgn(m_sh[c]);
                if (SLEW_STEP == 0) begin
                    m_act[c] = tgt; m_dir[c] = sg;
                end else if (sg != m_dir[c]) begin
                    m_act[c] = (m_act[c] > SLEW_STEP) ? m_act[c] - SLEW_STEP : 0;
                    if (m_act[c] == 0) m_dir[c] = sg;
                end else if (m_act[c] < tgt) begin
                    m_act[c] = (tgt - m_act[c] > SLEW_STEP) ? m_act[c] + SLEW_STEP : tgt;
                end else begin
                    m_act[c] = (m_act[c] - tgt > SLEW_STEP) ? m_act[c] - SLEW_STEP : tgt;
                end
            end
            if (duty_valid[c]) m_sh[c] = duty_val[c];
            m_pwm[c] = (enable && m_act[c] > DEADBAND && m_cnt < m_act[c] + OFFSET) ? 1 : 0;
        end
        m_ps = bnd ? 1 : 0;
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        model_edge();
        #1;
        cyc++;
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("model_pwm%0d", c), int'(pwm_out[c]), m_pwm[c]);
            chk($sformatf("model_dir%0d", c), int'(dir_out[c]), m_dir[c]);
        end
        chk("model_period_start", int'(period_start), m_ps);
    endtask

    task automatic set_duty(input int c, input int v);
        duty_val[c] = v;
        duty_in[c*IN_W +: IN_W] = IN_W'(v);
    endtask

    task automatic apply(input int v);
        for (int c = 0; c < CH; c++) set_duty(c, v);
        duty_valid = '1;
        step();
        duty_valid = '0;
    endtask

    task automatic sync_ps();
        for (int k = 0; k < 3 * PCLK; k++) begin
            step();
            if (period_start) return;
        end
        chk("period_start_timeout", 0, 1);
    endtask

    // Starts on a period_start sample, ends on the next one.
    task automatic measure(input int chg_at, input int chg_val);
        for (int c = 0; c < CH; c++) begin
            meas_hi[c]  = 0;
            meas_dir[c] = int'(dir_out[c]);
        end
        for (int k = 0; k < PCLK; k++) begin
            for (int c = 0; c < CH; c++) meas_hi[c] += int'(pwm_out[c]);
            if (k == chg_at) begin
                for (int c = 0; c < CH; c++) set_duty(c, chg_val);
                duty_valid = '1;
            end
            step();
            duty_valid = '0;
        end
        chk("period_start_interval", int'(period_start), 1);
    endtask

    task automatic chk_meas(input string name, input int hi, input int dr);
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("%s_hi%0d", name, c), meas_hi[c], hi);
            chk($sformatf("%s_dir%0d", name, c), meas_dir[c], dr);
        end
    endtask

    initial begin
        tbl[0] = '{3,   0,  0};
        tbl[1] = '{4,   12, 0};
        tbl[2] = '{10,  24, 0};
        tbl[3] = '{-10, 24, 1};
        tbl[4] = '{-32, 40, 1};
        tbl[5] = '{17,  38, 0};
        tbl[6] = '{18,  40, 0};
        tbl[7] = '{-3,  0,  1};
        tbl[8] = '{0,   0,  0};

        reset = 1'b1; enable = 1'b0; duty_in = '0; duty_valid = '1;
        for (int c = 0; c < CH; c++) set_duty(c, 10);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("reset_pwm", int'(pwm_out), 0);
            chk("reset_dir", int'(dir_out), 0);
            chk("reset_ps", int'(period_start), 0);
        end
        reset = 1'b0; duty_valid = '0; enable = 1'b1;

        for (int i = 0; i < 9; i++) begin
            apply(tbl[i].duty);
            sync_ps();
            for (int p = 0; p < 18; p++) measure(-1, 0);
            measure(-1, 0);
            chk_meas($sformatf("tbl%0d", i), tbl[i].exp_hi, tbl[i].exp_dir);
        end

        apply(8);
        sync_ps();
        measure(-1, 0);
        measure(-1, 0);
        chk_meas("slew_up8", 20, 0);
        measure(10, -8);
        chk_meas("midchange_old_width", 20, 0);
        measure(-1, 0); chk_meas("rev_a4", 12, 0);
        measure(-1, 0); chk_meas("rev_a0", 0, 1);
        measure(-1, 0); chk_meas("rev_b4", 12, 1);
        measure(-1, 0); chk_meas("rev_b8", 20, 1);

        measure(PCLK - 1, -10);
        chk_meas("bwrite_cur", 20, 1);
        measure(-1, 0); chk_meas("bwrite_still_old", 20, 1);
        measure(-1, 0); chk_meas("bwrite_applied", 24, 1);

        for (int k = 0; k < 15; k++) step();
        reset = 1'b1;
        step();
        chk("midreset_pwm", int'(pwm_out), 0);
        chk("midreset_dir", int'(dir_out), 0);
        chk("midreset_ps", int'(period_start), 0);
        reset = 1'b0;

        apply(-20);
        sync_ps();
        for (int p = 0; p < 7; p++) measure(-1, 0);
        for (int k = 0; k < 15; k++) step();
        chk("full_high_before_disable", int'(pwm_out), 3);
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("disable_pwm", int'(pwm_out), 0);
            chk("disable_dir_hold", int'(dir_out), 3);
        end
        enable = 1'b1;

        begin
            int en_low;
            en_low = 0;
            for (int k = 0; k < 3000; k++) begin
                reset = ($urandom % 700 == 0);
                if (en_low > 0) begin
                    enable = 1'b0;
                    en_low--;
                end else begin
                    enable = 1'b1;
                    if ($urandom % 150 == 0) en_low = $urandom_range(1, 30);
                end
                for (int c = 0; c < CH; c++) begin
                    duty_valid[c] = ($urandom % 25 == 0);
                    if (duty_valid[c]) set_duty(c, int'($urandom_range(0, 63)) - 32);
                end
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
